// File: rtl/mem_port_arbiter.sv
// Two-requester (I fetch / D load-store) arbiter for the single memory port of the AXI bridge.
// Runs one downstream transaction at a time and watches each grant with a sticky timeout flag.
module mem_port_arbiter #(
    parameter int unsigned RR_EN          = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_addr,
    input  logic        i_access,
    input  logic        i_write,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_st_data,
    output logic        i_ready,
    output logic [31:0] i_data,

    input  logic [31:0] d_addr,
    input  logic        d_access,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_st_data,
    output logic        d_ready,
    output logic [31:0] d_data,

    output logic [31:0] m_addr,
    output logic        m_access,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [3:0]  m_sel,
    output logic [31:0] m_st_data,
    input  logic        m_ready,
    input  logic [31:0] m_data,

    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;   // 1 = D granted last
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;
    logic              m_access_q, m_access_d;
    logic [31:0]       m_addr_q, m_addr_d;
    logic              m_write_q, m_write_d;
    logic [1:0]        m_size_q, m_size_d;
    logic [3:0]        m_sel_q, m_sel_d;
    logic [31:0]       m_st_data_q, m_st_data_d;
    logic              pick_d;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
        m_access_d  = m_access_q;
        m_addr_d    = m_addr_q;
        m_write_d   = m_write_q;
        m_size_d    = m_size_q;
        m_sel_d     = m_sel_q;
        m_st_data_d = m_st_data_q;
        pick_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_access || d_access) begin
                    if (i_access && d_access)
                        pick_d = (RR_EN == 0) ? 1'b1 : !last_gnt_q;
                    else
                        pick_d = d_access;
                    state_d     = pick_d ? GNT_D : GNT_I;
                    m_access_d  = 1'b1;
                    wd_cnt_d    = '0;
                    m_addr_d    = pick_d ? d_addr    : i_addr;
                    m_write_d   = pick_d ? d_write   : i_write;
                    m_size_d    = pick_d ? d_size    : i_size;
                    m_sel_d     = pick_d ? d_sel     : i_sel;
                    m_st_data_d = pick_d ? d_st_data : i_st_data;
                end
            end
            GNT_I, GNT_D: begin
                if (m_ready) begin
                    state_d    = IDLE;
                    m_access_d = 1'b0;
                    last_gnt_d = (state_q == GNT_D);
                end else begin
                    if (wd_cnt_q != '1)
                        wd_cnt_d = wd_cnt_q + CNT_W'(1);
                    // The grant keeps running after a timeout; AXI has no abort.
                    if (TIMEOUT_CYCLES != 0 && wd_cnt_q == WD_LAST)
                        err_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                m_access_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
            m_access_q  <= 1'b0;
            m_addr_q    <= '0;
            m_write_q   <= 1'b0;
            m_size_q    <= '0;
            m_sel_q     <= '0;
            m_st_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
            m_access_q  <= m_access_d;
            m_addr_q    <= m_addr_d;
            m_write_q   <= m_write_d;
            m_size_q    <= m_size_d;
            m_sel_q     <= m_sel_d;
            m_st_data_q <= m_st_data_d;
        end
    end

    assign m_access    = m_access_q;
    assign busy        = m_access_q;
    assign m_addr      = m_addr_q;
    assign m_write     = m_write_q;
    assign m_size      = m_size_q;
    assign m_sel       = m_sel_q;
    assign m_st_data   = m_st_data_q;
    assign err_timeout = err_q;

    assign i_ready = m_ready && (state_q == GNT_I);
    assign d_ready = m_ready && (state_q == GNT_D);
    assign i_data  = m_data;
    assign d_data  = m_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority, round-robin and watchdog-disabled
// instances share one stimulus stream and are checked against hand-computed values.
module tb_mem_port_arbiter;

    logic        clk, reset;
    logic [31:0] i_addr, i_st_data, d_addr, d_st_data, m_data;
    logic        i_access, i_write, d_access, d_write, m_ready;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_sel, d_sel;

    logic        fp_i_ready, fp_d_ready, fp_m_access, fp_m_write, fp_busy, fp_err;
    logic [31:0] fp_i_data, fp_d_data, fp_m_addr, fp_m_st_data;
    logic [1:0]  fp_m_size;
    logic [3:0]  fp_m_sel;

    logic        rr_i_ready, rr_d_ready, rr_m_access, rr_m_write, rr_busy, rr_err;
    logic [31:0] rr_i_data, rr_d_data, rr_m_addr, rr_m_st_data;
    logic [1:0]  rr_m_size;
    logic [3:0]  rr_m_sel;

    logic        nw_i_ready, nw_d_ready, nw_m_access, nw_m_write, nw_busy, nw_err;
    logic [31:0] nw_i_data, nw_d_data, nw_m_addr, nw_m_st_data;
    logic [1:0]  nw_m_size;
    logic [3:0]  nw_m_sel;

    int n_chk;
    int n_pass;

    mem_port_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_fp (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_access(i_access), .i_write(i_write), .i_size(i_size),
        .i_sel(i_sel), .i_st_data(i_st_data), .i_ready(fp_i_ready), .i_data(fp_i_data),
        .d_addr(d_addr), .d_access(d_access), .d_write(d_write), .d_size(d_size),
        .d_sel(d_sel), .d_st_data(d_st_data), .d_ready(fp_d_ready), .d_data(fp_d_data),
        .m_addr(fp_m_addr), .m_access(fp_m_access), .m_write(fp_m_write), .m_size(fp_m_size),
        .m_sel(fp_m_sel), .m_st_data(fp_m_st_data), .m_ready(m_ready), .m_data(m_data),
        .busy(fp_busy), .err_timeout(fp_err)
    );

    mem_port_arbiter #(.RR_EN(1), .TIMEOUT_CYCLES(8), .CNT_W(16)) u_rr (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_access(i_access), .i_write(i_write), .i_size(i_size),
        .i_sel(i_sel), .i_st_data(i_st_data), .i_ready(rr_i_ready), .i_data(rr_i_data),
        .d_addr(d_addr), .d_access(d_access), .d_write(d_write), .d_size(d_size),
        .d_sel(d_sel), .d_st_data(d_st_data), .d_ready(rr_d_ready), .d_data(rr_d_data),
        .m_addr(rr_m_addr), .m_access(rr_m_access), .m_write(rr_m_write), .m_size(rr_m_size),
        .m_sel(rr_m_sel), .m_st_data(rr_m_st_data), .m_ready(m_ready), .m_data(m_data),
        .busy(rr_busy), .err_timeout(rr_err)
    );

    mem_port_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(0), .CNT_W(16)) u_nw (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_access(i_access), .i_write(i_write), .i_size(i_size),
        .i_sel(i_sel), .i_st_data(i_st_data), .i_ready(nw_i_ready), .i_data(nw_i_data),
        .d_addr(d_addr), .d_access(d_access), .d_write(d_write), .d_size(d_size),
        .d_sel(d_sel), .d_st_data(d_st_data), .d_ready(nw_d_ready), .d_data(nw_d_data),
        .m_addr(nw_m_addr), .m_access(nw_m_access), .m_write(nw_m_write), .m_size(nw_m_size),
        .m_sel(nw_m_sel), .m_st_data(nw_m_st_data), .m_ready(m_ready), .m_data(m_data),
        .busy(nw_busy), .err_timeout(nw_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        i_access = 1'b0; i_addr = '0; i_write = 1'b0; i_size = '0; i_sel = '0; i_st_data = '0;
        d_access = 1'b0; d_addr = '0; d_write = 1'b0; d_size = '0; d_sel = '0; d_st_data = '0;
        m_ready = 1'b0; m_data = '0;

        // reset state
        @(negedge clk);
        chk("rst_m_access", fp_m_access, 0);
        chk("rst_busy", fp_busy, 0);
        chk("rst_m_addr", fp_m_addr, 0);
        chk("rst_err", fp_err, 0);
        chk("rst_rr_m_access", rr_m_access, 0);
        reset = 1'b0;

        // single D read, bridge answers 3 cycles after m_access
        d_access = 1'b1; d_addr = 32'h1000_0010; d_size = 2'd2; d_sel = 4'hF;
        @(negedge clk);
        chk("rd_m_access", fp_m_access, 1);
        chk("rd_m_addr", fp_m_addr, 32'h1000_0010);
        chk("rd_m_size", fp_m_size, 2);
        chk("rd_busy", fp_busy, 1);
        chk("rd_rr_m_addr", rr_m_addr, 32'h1000_0010);
        @(negedge clk);
        @(negedge clk);
        chk("rd_wait_d_ready", fp_d_ready, 0);
        @(negedge clk);
        m_ready = 1'b1; m_data = 32'hDEAD_BEEF;
        #1;
        chk("rd_d_ready", fp_d_ready, 1);
        chk("rd_d_data", fp_d_data, 32'hDEAD_BEEF);
        chk("rd_i_ready", fp_i_ready, 0);
        chk("rd_rr_d_ready", rr_d_ready, 1);
        @(negedge clk);
        m_ready = 1'b0; m_data = '0; d_access = 1'b0;
        chk("rd_idle_m_access", fp_m_access, 0);
        chk("rd_idle_busy", fp_busy, 0);
        chk("rd_idle_d_ready", fp_d_ready, 0);

        // m_ready outside a grant is ignored
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("stray_i_ready", fp_i_ready, 0);
        chk("stray_d_ready", fp_d_ready, 0);
        @(negedge clk);
        m_ready = 1'b0;
        chk("stray_m_access", fp_m_access, 0);
        chk("stray_err", fp_err, 0);

        // tie: fixed priority gives D,D,D,D; round robin from reset gives D,I,D,I
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_access = 1'b1; i_addr = 32'h0000_0100; i_size = 2'd2;
        d_access = 1'b1; d_addr = 32'h0000_0200; d_size = 2'd2;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("tie_fp_addr", fp_m_addr, 32'h0000_0200);
            chk("tie_rr_addr", rr_m_addr, (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
            m_ready = 1'b1; m_data = 32'h0000_00A0 + 32'(t);
            #1;
            chk("tie_fp_d_ready", fp_d_ready, 1);
            chk("tie_fp_i_ready", fp_i_ready, 0);
            chk("tie_rr_i_ready", rr_i_ready, 32'(t % 2));
            chk("tie_rr_i_data", rr_i_data, 32'h0000_00A0 + 32'(t));
            @(negedge clk);
            m_ready = 1'b0;
            chk("tie_fp_gap", fp_m_access, 0);
            chk("tie_rr_gap", rr_m_access, 0);
        end

        // D write; fields must stay registered even if the requester changes them
        i_access = 1'b0;
        d_addr = 32'h0000_0300; d_write = 1'b1; d_sel = 4'b0011; d_st_data = 32'h0000_ABCD; d_size = 2'd1;
        @(negedge clk);
        chk("wr_m_write", fp_m_write, 1);
        chk("wr_m_sel", fp_m_sel, 4'h3);
        chk("wr_m_st_data", fp_m_st_data, 32'h0000_ABCD);
        chk("wr_m_addr", fp_m_addr, 32'h0000_0300);
        d_st_data = 32'hFFFF_FFFF; d_sel = 4'hF;
        @(negedge clk);
        chk("wr_hold_st_data", fp_m_st_data, 32'h0000_ABCD);
        chk("wr_hold_sel", fp_m_sel, 4'h3);
        m_ready = 1'b1;
        #1;
        chk("wr_d_ready", fp_d_ready, 1);
        @(negedge clk);
        m_ready = 1'b0; d_access = 1'b0; d_write = 1'b0;
        chk("wr_d_ready_pulse", fp_d_ready, 0);
        chk("wr_idle", fp_m_access, 0);
        chk("wr_err", fp_err, 0);

        // watchdog: 8-cycle timeout, m_ready withheld for 10 grant cycles
        d_access = 1'b1; d_addr = 32'h0000_0400;
        repeat (7) @(negedge clk);
        chk("wd_early_fp", fp_err, 0);
        chk("wd_early_rr", rr_err, 0);
        repeat (3) @(negedge clk);
        chk("wd_fp_err", fp_err, 1);
        chk("wd_rr_err", rr_err, 1);
        chk("wd_nw_err", nw_err, 0);
        chk("wd_still_granted", fp_m_access, 1);
        m_ready = 1'b1; m_data = 32'h1234_5678;
        #1;
        chk("wd_d_ready", fp_d_ready, 1);
        chk("wd_d_data", fp_d_data, 32'h1234_5678);
        @(negedge clk);
        m_ready = 1'b0; d_access = 1'b0;
        chk("wd_sticky", fp_err, 1);
        chk("wd_done", fp_m_access, 0);

        // asynchronous reset in the middle of an I grant
        i_access = 1'b1; i_addr = 32'h0000_0500; i_size = 2'd2;
        @(negedge clk);
        chk("ar_m_access_pre", fp_m_access, 1);
        chk("ar_m_addr_pre", fp_m_addr, 32'h0000_0500);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_m_access", fp_m_access, 0);
        chk("ar_busy", fp_busy, 0);
        chk("ar_err", fp_err, 0);
        chk("ar_rr_m_access", rr_m_access, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_regrant", fp_m_access, 1);
        chk("ar_regrant_addr", fp_m_addr, 32'h0000_0500);
        m_ready = 1'b1; m_data = 32'hCAFE_F00D;
        #1;
        chk("ar_i_ready", fp_i_ready, 1);
        chk("ar_i_data", fp_i_data, 32'hCAFE_F00D);
        chk("ar_d_ready", fp_d_ready, 0);
        @(negedge clk);
        m_ready = 1'b0; i_access = 1'b0;
        chk("ar_done", fp_m_access, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
